// File: rtl/l74x194.sv
// Universal bidirectional shift register (74x194 function): hold, shift right,
// shift left, parallel load, async clear, plus registered one-hot end flags.
module l74x194 #(
    parameter int unsigned       WIDTH       = 4,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ce,
    input  logic [1:0]       i_s,
    input  logic             i_dsr,
    input  logic             i_dsl,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_first,
    output logic             o_last
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ONE_FIRST   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ONE_LAST    = ONE_FIRST << (WIDTH - 1);
    localparam logic             RST_FIRST   = (RESET_VALUE == ONE_FIRST);
    localparam logic             RST_LAST    = (RESET_VALUE == ONE_LAST);

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("l74x194: WIDTH must be in 2..16");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic             r_first;
    logic             r_last;

    logic [WIDTH-1:0] w_q_next;
    logic             w_first_next;
    logic             w_last_next;
    mode_e            w_mode;

    // Next-state selection; flags derive from the next value so they track o_q exactly.
    always_comb begin
        w_q_next = r_q;
        w_mode   = mode_e'(i_s);
        if (i_ce) begin
            case (w_mode)
                MODE_HOLD: w_q_next = r_q;
                MODE_SHR:  w_q_next = {r_q[WIDTH-2:0], i_dsr};
                MODE_SHL:  w_q_next = {i_dsl, r_q[WIDTH-1:1]};
                MODE_LOAD: w_q_next = i_d;
                default:   w_q_next = r_q;
            endcase
        end
        w_first_next = (w_q_next == ONE_FIRST);
        w_last_next  = (w_q_next == ONE_LAST);
    end

    // Clear is asynchronous and wins over any edge in progress.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q     <= RESET_VALUE;
            r_first <= RST_FIRST;
            r_last  <= RST_LAST;
        end else begin
            r_q     <= w_q_next;
            r_first <= w_first_next;
            r_last  <= w_last_next;
        end
    end

    assign o_q     = r_q;
    assign o_first = r_first;
    assign o_last  = r_last;

endmodule

// File: tb/tb_l74x194.sv
// Bench for l74x194: two 4-bit instances (clear to 0 and to 1) plus an 8-bit
// Larson scanner with rotate loopback, checked against an arithmetic model.
module tb_l74x194;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce, dsr, dsl;
    logic [1:0] s;
    logic [3:0] d;
    logic       ce8;
    logic [1:0] s8;
    logic [7:0] d8;

    logic [3:0] q0, q1;
    logic       f0, l0, f1, l1;
    logic [7:0] q8;
    logic       f8, l8;
    logic       dsr8, dsl8;

    logic [15:0] m0, m1, m8;
    logic        chk_en;
    int          vectors = 0;
    int          errors  = 0;

    always #5 clk = ~clk;

    assign dsr8 = q8[7];
    assign dsl8 = q8[0];

    l74x194 #(.WIDTH(4), .RESET_VALUE(4'd0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_s(s), .i_dsr(dsr), .i_dsl(dsl),
        .i_d(d), .o_q(q0), .o_first(f0), .o_last(l0));

    l74x194 #(.WIDTH(4), .RESET_VALUE(4'd1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce), .i_s(s), .i_dsr(dsr), .i_dsl(dsl),
        .i_d(d), .o_q(q1), .o_first(f1), .o_last(l1));

    l74x194 #(.WIDTH(8), .RESET_VALUE(8'd0)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce8), .i_s(s8), .i_dsr(dsr8), .i_dsl(dsl8),
        .i_d(d8), .o_q(q8), .o_first(f8), .o_last(l8));

    // Behavioural model: register as an integer, modes as arithmetic.
    function automatic logic [15:0] mdl(input logic [15:0] q, input int w, input logic en,
                                        input logic [1:0] mode, input logic sr, input logic sl,
                                        input logic [15:0] pd);
        logic [15:0] mask;
        mask = (16'(1) << w) - 16'(1);
        if (!en) return q;
        case (mode)
            2'd1:    return ((q << 1) | 16'(sr)) & mask;
            2'd2:    return (q >> 1) | (16'(sl) << (w - 1));
            2'd3:    return pd & mask;
            default: return q;
        endcase
    endfunction

    function automatic logic is_first(input logic [15:0] q);
        return q == 16'd1;
    endfunction

    function automatic logic is_last(input logic [15:0] q, input int w);
        return q == (16'(1) << (w - 1));
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " q0"}, 16'(q0), m0);
        check({tag, " first0"}, 16'(f0), 16'(is_first(m0)));
        check({tag, " last0"}, 16'(l0), 16'(is_last(m0, 4)));
        check({tag, " q1"}, 16'(q1), m1);
        check({tag, " first1"}, 16'(f1), 16'(is_first(m1)));
        check({tag, " last1"}, 16'(l1), 16'(is_last(m1, 4)));
        check({tag, " q8"}, 16'(q8), m8);
        check({tag, " first8"}, 16'(f8), 16'(is_first(m8)));
        check({tag, " last8"}, 16'(l8), 16'(is_last(m8, 8)));
    endtask

    // One clock edge; the model advances with the inputs the DUT sampled.
    task automatic edge_step();
        @(posedge clk);
        if (rst_n) begin
            m0 = mdl(m0, 4, ce, s, dsr, dsl, 16'(d));
            m1 = mdl(m1, 4, ce, s, dsr, dsl, 16'(d));
            m8 = mdl(m8, 8, ce8, s8, m8[7], m8[0], 16'(d8));
        end
        #1;
    endtask

    task automatic set_reset_model();
        m0 = 16'h0;
        m1 = 16'h1;
        m8 = 16'h0;
    endtask

    always @(negedge clk) begin
        if (chk_en) check_all("cyc");
    end

    always @(posedge clk) begin
        if (rst_n === 1'b1 && ce === 1'b1)
            assert (!$isunknown(s)) else $error("mode select unknown while enabled");
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        chk_en = 1'b0;
        rst_n = 1'b1;
        ce = 1'b0; s = 2'b00; dsr = 1'b0; dsl = 1'b0; d = 4'h0;
        ce8 = 1'b0; s8 = 2'b00; d8 = 8'h00;
        set_reset_model();

        // Mid-cycle clear with no clock edge.
        #1 rst_n = 1'b0;
        #1;
        check_all("reset");
        check("reset q1 lit", 16'(q1), 16'h1);
        check("reset first1 lit", 16'(f1), 16'h1);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Parallel load then hold.
        ce = 1'b1; s = 2'b11; d = 4'b1010;
        edge_step();
        check("load lit", 16'(q0), 16'hA);
        s = 2'b00; d = 4'b0101;
        repeat (3) edge_step();
        check("hold lit", 16'(q0), 16'hA);

        // Shift right a single bit from QA to the last stage.
        s = 2'b11; d = 4'b0001;
        edge_step();
        check("load1 first lit", 16'(f0), 16'h1);
        s = 2'b01; dsr = 1'b0;
        edge_step();
        check("shr1 lit", 16'(q0), 16'h2);
        check("shr1 first lit", 16'(f0), 16'h0);
        edge_step();
        check("shr2 lit", 16'(q0), 16'h4);
        edge_step();
        check("shr3 lit", 16'(q0), 16'h8);
        check("shr3 last lit", 16'(l0), 16'h1);

        // Shift left filling ones from the last stage.
        s = 2'b10; dsl = 1'b1;
        edge_step();
        check("shl1 lit", 16'(q0), 16'hC);
        check("shl1 last lit", 16'(l0), 16'h0);
        edge_step();
        check("shl2 lit", 16'(q0), 16'hE);

        // Clock enable low freezes everything.
        ce = 1'b0; s = 2'b01; dsr = 1'b1;
        repeat (5) edge_step();
        check("ce0 lit", 16'(q0), 16'hE);

        // Clear asserted just before a shift edge: no shifted value may appear.
        ce = 1'b1; s = 2'b01; dsr = 1'b1;
        #8;
        rst_n = 1'b0;
        set_reset_model();
        @(posedge clk);
        #1;
        check("rst shift q0 lit", 16'(q0), 16'h0);
        check("rst shift q1 lit", 16'(q1), 16'h1);
        #2 rst_n = 1'b1;
        ce = 1'b0; s = 2'b00; dsr = 1'b0;

        // Larson sweep on the 8-bit instance with rotate loopback.
        ce8 = 1'b1; s8 = 2'b11; d8 = 8'h01;
        edge_step();
        check("larson start lit", 16'(q8), 16'h01);
        for (int i = 0; i < 14; i++) begin
            if (l8) s8 = 2'b10;
            else if (f8) s8 = 2'b01;
            edge_step();
            check("larson step", 16'(q8), (i < 7) ? (16'(1) << (i + 1)) : (16'(1) << (13 - i)));
            check("larson onehot", 16'($onehot(q8)), 16'h1);
        end
        check("larson end lit", 16'(q8), 16'h01);
        check("larson end first lit", 16'(f8), 16'h1);
        ce8 = 1'b0;

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
